// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache request arbiter.
package cache_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StWait,
    StDone
  } state_t;

  localparam int unsigned PORT_LOADER = 0;
  localparam int unsigned PORT_CORE   = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port not served last wins.
module rr_pick2 (
  input  logic [1:0] i_elig,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_elig;
    if (i_elig == 2'b11) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the boot loader and core ports onto the single cache request port and
// sequences the cache's strobe / wait-busy / wait-ready protocol with a watchdog.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_done,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [1:0]  grant,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic [31:0] cache_data_out,
  input  logic        cache_data_out_ready,
  input  logic        cache_busy
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_state_d;
  logic [1:0]      r_grant, w_grant_d;
  logic            r_last, w_last_d;
  logic [WdW-1:0]  r_wd, w_wd_d;
  req_t            r_req, w_req_d;
  logic [3:0]      r_cache_we, w_cache_we_d;
  logic [1:0]      r_ack, w_ack_d;
  logic [1:0]      r_err, w_err_d;
  logic [31:0]     r_rdata0, w_rdata0_d;
  logic [31:0]     r_rdata1, w_rdata1_d;

  logic [1:0]      w_elig;
  logic [1:0]      w_pick;
  req_t            w_req0, w_req1;
  logic            w_owner;
  logic            w_is_write;
  logic            w_complete;
  logic [31:0]     w_rd_value;

  assign w_elig[PORT_LOADER] = m0_req;
  assign w_elig[PORT_CORE]   = m1_req & boot_done;

  assign w_req0 = '{addr: m0_addr, wdata: m0_wdata, we: m0_we};
  assign w_req1 = '{addr: m1_addr, wdata: m1_wdata, we: m1_we};

  rr_pick2 u_pick (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  assign w_owner    = r_grant[PORT_CORE];
  assign w_is_write = |r_req.we;
  assign w_complete = w_is_write ? ~cache_busy : cache_data_out_ready;
  assign w_rd_value = w_complete ? cache_data_out : 32'h0;

  always_comb begin
    w_state_d    = r_state;
    w_grant_d    = r_grant;
    w_last_d     = r_last;
    w_wd_d       = r_wd;
    w_req_d      = r_req;
    w_cache_we_d = 4'h0;
    w_ack_d      = 2'b00;
    w_err_d      = 2'b00;
    w_rdata0_d   = r_rdata0;
    w_rdata1_d   = r_rdata1;

    unique case (r_state)
      StIdle: begin
        if (|w_pick) begin
          w_grant_d    = w_pick;
          w_req_d      = w_pick[PORT_CORE] ? w_req1 : w_req0;
          w_cache_we_d = w_req_d.we;
          w_state_d    = StIssue;
        end
      end
      StIssue: begin
        w_state_d = StSettle;
      end
      StSettle: begin
        w_wd_d    = '0;
        w_state_d = StWait;
      end
      StWait: begin
        // A genuine completion wins over a watchdog expiry in the same cycle.
        if (w_complete || (r_wd == WdMax)) begin
          w_ack_d[w_owner] = 1'b1;
          w_err_d[w_owner] = ~w_complete;
          if (!w_is_write) begin
            if (w_owner) begin
              w_rdata1_d = w_rd_value;
            end else begin
              w_rdata0_d = w_rd_value;
            end
          end
          w_last_d  = w_owner;
          w_state_d = StDone;
        end else begin
          w_wd_d = r_wd + 1'b1;
        end
      end
      StDone: begin
        w_grant_d = 2'b00;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_wd       <= '0;
      r_req      <= '0;
      r_cache_we <= 4'h0;
      r_ack      <= 2'b00;
      r_err      <= 2'b00;
      r_rdata0   <= 32'h0;
      r_rdata1   <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_last     <= w_last_d;
      r_wd       <= w_wd_d;
      r_req      <= w_req_d;
      r_cache_we <= w_cache_we_d;
      r_ack      <= w_ack_d;
      r_err      <= w_err_d;
      r_rdata0   <= w_rdata0_d;
      r_rdata1   <= w_rdata1_d;
    end
  end

  assign grant              = r_grant;
  assign cache_address      = r_req.addr;
  assign cache_data_in      = r_req.wdata;
  assign cache_write_enable = r_cache_we;
  assign m0_ack             = r_ack[PORT_LOADER];
  assign m1_ack             = r_ack[PORT_CORE];
  assign m0_err             = r_err[PORT_LOADER];
  assign m1_err             = r_err[PORT_CORE];
  assign m0_rdata           = r_rdata0;
  assign m1_rdata           = r_rdata1;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a cache model, a transaction-level timing model checked every
// cycle, and directed scenarios with hand-computed latencies and data.
module tb_cache_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_done = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  grant;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0]  cache_write_enable;
  logic [31:0] cache_data_out = '0;
  logic        cache_data_out_ready = 1'b0;
  logic        cache_busy = 1'b0;

  cache_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .boot_done            (boot_done),
    .m0_req               (m0_req),
    .m0_addr              (m0_addr),
    .m0_wdata             (m0_wdata),
    .m0_we                (m0_we),
    .m0_ack               (m0_ack),
    .m0_rdata             (m0_rdata),
    .m0_err               (m0_err),
    .m1_req               (m1_req),
    .m1_addr              (m1_addr),
    .m1_wdata             (m1_wdata),
    .m1_we                (m1_we),
    .m1_ack               (m1_ack),
    .m1_rdata             (m1_rdata),
    .m1_err               (m1_err),
    .grant                (grant),
    .cache_address        (cache_address),
    .cache_data_in        (cache_data_in),
    .cache_write_enable   (cache_write_enable),
    .cache_data_out       (cache_data_out),
    .cache_data_out_ready (cache_data_out_ready),
    .cache_busy           (cache_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Cache behaviour knobs, held constant across each transaction.
  int busy_lat = 0;
  int rd_lat = 2;
  bit ready_en = 1'b1;

  logic [31:0] cmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] c_rd(input logic [31:0] a);
    return cmem.exists(a) ? cmem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Cache model: busy lags the write strobe by one cycle; read data is ready rd_lat
  // cycles after the issue cycle and stays up until the grant drops.
  int          c_issue = 0;
  logic [31:0] c_addr = '0;
  logic [3:0]  c_we = '0;
  logic [1:0]  c_prev_grant = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (grant != 2'b00 && c_prev_grant == 2'b00) begin
        c_issue = cyc;
        c_addr  = cache_address;
        c_we    = cache_write_enable;
        if (c_we != 4'h0) cmem[c_addr] = merge(c_rd(c_addr), cache_data_in, c_we);
      end
      c_prev_grant = grant;
      cache_busy = (c_we != 4'h0) && (grant != 2'b00) && (cyc >= c_issue + 1) &&
                   (cyc <= c_issue + busy_lat);
      cache_data_out_ready = (c_we == 4'h0) && ready_en && (grant != 2'b00) &&
                             (cyc >= c_issue + rd_lat);
      cache_data_out = cache_data_out_ready ? c_rd(c_addr) : 32'hBAD0_0000;
    end
  end

  // Transaction-level model: each accepted request is reduced to an issue cycle and an
  // ack cycle computed from the cache knobs; outputs follow from those two numbers.
  bit          m_started = 1'b0;
  bit          m_act = 1'b0;
  bit          m_err = 1'b0;
  bit          m_last = 1'b1;
  int          m_owner = 0, m_i = 0, m_a = 0, m_comp = 0, m_tmo = 0, m_rdy = 0;
  logic [3:0]  t_we = '0;
  logic [31:0] t_rdata = '0, t_addr = '0, t_wdata = '0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  logic [1:0]  x_grant;
  logic [3:0]  x_cwe;
  logic        x_ack0, x_ack1, x_err0, x_err1, s_e0, s_e1;
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        x_grant = (m_act && cyc >= m_i && cyc <= m_a) ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00;
        x_cwe   = (m_act && cyc == m_i) ? t_we : 4'h0;
        x_ack0  = m_act && cyc == m_a && m_owner == 0;
        x_ack1  = m_act && cyc == m_a && m_owner == 1;
        x_err0  = x_ack0 && m_err;
        x_err1  = x_ack1 && m_err;
        check("grant", 32'(grant), 32'(x_grant));
        check("cache_write_enable", 32'(cache_write_enable), 32'(x_cwe));
        check("cache_address", cache_address, e_addr);
        check("cache_data_in", cache_data_in, e_wdata);
        check("m0_ack", 32'(m0_ack), 32'(x_ack0));
        check("m1_ack", 32'(m1_ack), 32'(x_ack1));
        check("m0_err", 32'(m0_err), 32'(x_err0));
        check("m1_err", 32'(m1_err), 32'(x_err1));
        check("m0_rdata", m0_rdata, e_rd0);
        check("m1_rdata", m1_rdata, e_rd1);
      end
      if (!rst_n) begin
        m_started = 1'b1;
        m_act = 1'b0;
        m_last = 1'b1;
        e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (m_started) begin
        if (m_act && cyc == m_a) begin
          m_act  = 1'b0;
          m_last = (m_owner == 1);
        end else if (!m_act) begin
          s_e0 = m0_req;
          s_e1 = m1_req && boot_done;
          if (s_e0 || s_e1) begin
            if (s_e0 && s_e1) m_owner = m_last ? 0 : 1;
            else m_owner = s_e1 ? 1 : 0;
            t_addr  = (m_owner == 1) ? m1_addr : m0_addr;
            t_wdata = (m_owner == 1) ? m1_wdata : m0_wdata;
            t_we    = (m_owner == 1) ? m1_we : m0_we;
            m_i = cyc + 1;
            m_err = 1'b0;
            if (t_we != 4'h0) begin
              m_comp = (busy_lat + 1 > 2) ? m_i + busy_lat + 1 : m_i + 2;
              mmem[t_addr] = merge(m_rd(t_addr), t_wdata, t_we);
            end else begin
              m_tmo = m_i + 2 + int'(TO) - 1;
              m_rdy = (rd_lat > 2) ? m_i + rd_lat : m_i + 2;
              if (!ready_en || m_rdy > m_tmo) begin
                m_comp = m_tmo;
                m_err  = 1'b1;
              end else begin
                m_comp = m_rdy;
              end
              t_rdata = m_err ? 32'h0 : m_rd(t_addr);
            end
            m_a = m_comp + 1;
            e_addr = t_addr;
            e_wdata = t_wdata;
            m_act = 1'b1;
          end
        end
        if (m_act && cyc + 1 == m_a && t_we == 4'h0) begin
          if (m_owner == 1) e_rd1 = t_rdata;
          else e_rd0 = t_rdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port, input int bound, output int ack_cyc, output int wcnt);
    ack_cyc = -1;
    wcnt = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cache_write_enable == 4'hF) wcnt++;
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) begin
        ack_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic xact(input int port, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] we, output int lat, output int wcnt,
                      output logic [31:0] rd, output logic er);
    int t, ac;
    if (port == 1) begin
      m1_addr = a; m1_wdata = d; m1_we = we; m1_req = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = d; m0_we = we; m0_req = 1'b1;
    end
    t = cyc;
    wait_ack(port, 60, ac, wcnt);
    rd  = (port == 1) ? m1_rdata : m0_rdata;
    er  = (port == 1) ? m1_err : m0_err;
    lat = (ac < 0) ? -1 : ac - t;
    tick();
    if (port == 1) m1_req = 1'b0;
    else m0_req = 1'b0;
  endtask

  int          lat, wc, ac, t, bad, n0, n1, p;
  logic [31:0] rd;
  logic        er, got;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Loader write before boot: busy for 3 cycles after the strobe.
    busy_lat = 3;
    xact(0, 32'h40, 32'hDEAD_BEEF, 4'hF, lat, wc, rd, er);
    check("loader_wr_latency", lat, 6);
    check("loader_wr_strobe_cycles", wc, 1);
    check("loader_wr_err", 32'(er), 0);

    // Core port locked out until boot_done.
    rd_lat = 2;
    m1_addr = 32'h500; m1_wdata = '0; m1_we = 4'h0; m1_req = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (grant == 2'b10 || m1_ack) bad++;
    end
    check("preboot_m1_activity", bad, 0);
    tick();
    boot_done = 1'b1;
    t = cyc;
    wait_ack(1, 60, ac, wc);
    check("postboot_latency", (ac < 0) ? -1 : ac - t, 4);
    check("postboot_rdata", m1_rdata, 32'hC0DE_0500);
    tick();
    m1_req = 1'b0;

    // Write from the loader then read back through the core port.
    busy_lat = 1;
    xact(0, 32'h100, 32'h1234_5678, 4'hF, lat, wc, rd, er);
    check("rt_wr_latency", lat, 4);
    xact(1, 32'h100, 32'h0, 4'h0, lat, wc, rd, er);
    check("rt_rd_latency", lat, 4);
    check("rt_rdata", rd, 32'h1234_5678);

    // Read that the cache never answers.
    ready_en = 1'b0;
    xact(0, 32'h700, 32'h0, 4'h0, lat, wc, rd, er);
    check("timeout_latency", lat, 19);
    check("timeout_err", 32'(er), 1);
    check("timeout_rdata", rd, 32'h0);
    ready_en = 1'b1;

    // Reset while waiting on a read; the held request is then re-served.
    ready_en = 1'b0;
    m0_addr = 32'h800; m0_wdata = '0; m0_we = 4'h0; m0_req = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ready_en = 1'b1;
    t = cyc;
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_cache_we", 32'(cache_write_enable), 0);
    check("rst_cache_address", cache_address, 32'h0);
    check("rst_m0_ack", 32'(m0_ack), 0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    wait_ack(0, 60, ac, wc);
    check("rst_reserve_latency", (ac < 0) ? -1 : ac - t, 4);
    check("rst_reserve_rdata", m0_rdata, 32'hC0DE_0800);
    tick();
    m0_req = 1'b0;

    // Contention from a fresh reset: both ports request back to back.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    busy_lat = 2;
    rd_lat = 3;
    n0 = 0;
    n1 = 0;
    m0_addr = 32'h300; m0_wdata = 32'hA000_0000; m0_we = 4'hF;
    m1_addr = 32'h200; m1_wdata = 32'h0; m1_we = 4'h0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (m0_ack || m1_ack) begin
          got = 1'b1;
          break;
        end
      end
      check("cont_ack_seen", 32'(got), 1);
      if (!got) break;
      p = m1_ack ? 1 : 0;
      check("cont_order", p, k % 2);
      if (p == 1) begin
        check("cont_m1_rdata", m1_rdata, (32'h200 + 32'(4 * n1)) ^ 32'hC0DE_0000);
        n1++;
      end else begin
        n0++;
      end
      tick();
      if (p == 1) begin
        m1_addr = 32'h200 + 32'(4 * n1);
      end else begin
        m0_addr  = 32'h300 + 32'(4 * n0);
        m0_wdata = 32'hA000_0000 + 32'(n0);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("cont_m0_acks", n0, 4);
    check("cont_m1_acks", n1, 4);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
